// File: rtl/wide_add_seq.sv
// Word-serial wide adder/subtractor: one N-bit parallel-prefix adder is reused
// LSW first, with the word carry registered between cycles.

module prefix #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);
   logic [N-1:0] g_grp;
   logic [N-1:0] p_grp;
   logic [N-1:0] g_nxt;
   logic [N-1:0] p_nxt;
   logic [N:0]   carry;

   // Kogge-Stone span doubling: after the last level bit i holds the (G,P) of [i:0]
   always_comb begin
      g_grp = a & b;
      p_grp = a ^ b;
      g_nxt = '0;
      p_nxt = '0;
      for (int lv = 1; lv < N; lv = lv * 2) begin
         g_nxt = g_grp;
         p_nxt = p_grp;
         for (int i = lv; i < N; i++) begin
            g_nxt[i] = g_grp[i] | (p_grp[i] & g_grp[i-lv]);
            p_nxt[i] = p_grp[i] & p_grp[i-lv];
         end
         g_grp = g_nxt;
         p_grp = p_nxt;
      end
   end

   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_carry
         assign carry[gi+1] = g_grp[gi] | (p_grp[gi] & cin);
      end
   endgenerate

   assign s    = a ^ b ^ carry[N-1:0];
   assign cout = carry[N];
endmodule

module wide_add_seq #(
   parameter int N     = 32,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   input  logic               sub,
   input  logic               cin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WORDS-1:0] sum,
   output logic               cout,
   output logic               ovf,
   output logic               busy
);
   localparam int W  = N * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          carry_q;
   logic [IW-1:0] idx_q;
   logic [W-1:0]  sum_q;
   logic          cout_q;
   logic          ovf_q;

   logic [N-1:0]  add_a;
   logic [N-1:0]  add_b;
   logic [N-1:0]  add_s;
   logic          add_co;
   logic          last_word;

   assign add_a     = a_q[idx_q*N +: N];
   assign add_b     = b_q[idx_q*N +: N];
   assign last_word = (idx_q == IW'(WORDS - 1));

   prefix #(.N(N)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_co)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  // Subtraction is A + ~B + 1, so B is stored pre-inverted
                  b_q     <= b ^ {W{sub}};
                  carry_q <= sub | cin;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[idx_q*N +: N] <= add_s;
               carry_q             <= add_co;
               if (last_word) begin
                  idx_q   <= '0;
                  cout_q  <= add_co;
                  ovf_q   <= (add_a[N-1] == add_b[N-1]) && (add_s[N-1] != add_a[N-1]);
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule
